// File: rtl/lector_ad_year_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lector_ad_year_pkg
// Brief    : Shared state encoding and defaults for the RTC year reader.
// Revision : 1.0 - initial release
// ============================================================================
package lector_ad_year_pkg;

    localparam logic [7:0]  C_ADDR_YEAR_DEF = 8'h26;
    localparam int unsigned C_T_PHASE_DEF   = 4;
    localparam logic [3:0]  C_BCD_MAX       = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_AHOLD = 3'd2,
        S_TURN  = 3'd3,
        S_READ  = 3'd4,
        S_RECOV = 3'd5,
        S_DONE  = 3'd6
    } state_e;

endpackage : lector_ad_year_pkg
`default_nettype wire

// File: rtl/lector_ad_year_if.sv
`default_nettype none
// ============================================================================
// Module   : lector_ad_year_if
// Brief    : Multiplexed address/data RTC bus with strobes.
// Revision : 1.0 - initial release
// ============================================================================
interface lector_ad_year_if;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       ad_n;
    logic       rd_n;

    modport master (input ad_in, output ad_out, ad_oe, cs_n, ad_n, rd_n);
    modport slave  (output ad_in, input ad_out, ad_oe, cs_n, ad_n, rd_n);
endinterface : lector_ad_year_if
`default_nettype wire

// File: rtl/lector_ad_year_bcd_a_bin.sv
`default_nettype none
// ============================================================================
// Module   : bcd_a_bin
// Brief    : Packed-BCD legality check and conversion to 7-bit binary.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_a_bin
    import lector_ad_year_pkg::*;
(
    input  wire logic [7:0] i_bcd,
    output logic      [6:0] o_bin,
    output logic            o_ok
);
    logic [3:0] w_tens;
    logic [3:0] w_units;

    always_comb begin
        w_tens  = i_bcd[7:4];
        w_units = i_bcd[3:0];
        o_ok    = (w_tens <= C_BCD_MAX) && (w_units <= C_BCD_MAX);
        o_bin   = ({3'b000, w_tens} * 7'd10) + {3'b000, w_units};
    end
endmodule : bcd_a_bin
`default_nettype wire

// File: rtl/lector_ad_year.sv
`default_nettype none
// ============================================================================
// Module   : lector_ad_year
// Brief    : Reads the year byte from a multiplexed-bus RTC and reports it.
// Revision : 1.0 - initial release
// ============================================================================
module lector_ad_year
    import lector_ad_year_pkg::*;
#(
    parameter logic [7:0]  ADDR_YEAR = C_ADDR_YEAR_DEF,
    parameter int unsigned T_PHASE   = C_T_PHASE_DEF
)(
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        start,
    lector_ad_year_if.master bus,
    output logic             busy,
    output logic [7:0]       year_bcd,
    output logic [6:0]       year_bin,
    output logic             valid,
    output logic             err
);
    localparam logic [3:0] C_PH_LAST = 4'(T_PHASE - 1);

    state_e     state_q, state_d;
    logic [3:0] phase_q, phase_d;
    logic [7:0] cap_q, cap_d;
    logic       cs_n_q, cs_n_d, ad_n_q, ad_n_d, rd_n_q, rd_n_d;
    logic       ad_oe_q, ad_oe_d, busy_q, busy_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic [7:0] year_bcd_q, year_bcd_d;
    logic [6:0] year_bin_q, year_bin_d;
    logic       valid_q, valid_d, err_q, err_d;
    logic       w_phase_last;
    logic [6:0] w_bin;
    logic       w_ok;

    bcd_a_bin u_bcd (
        .i_bcd (cap_q),
        .o_bin (w_bin),
        .o_ok  (w_ok)
    );

    always_comb begin
        state_d      = state_q;
        cap_d        = cap_q;
        year_bcd_d   = year_bcd_q;
        year_bin_d   = year_bin_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        w_phase_last = (phase_q == C_PH_LAST);

        unique case (state_q)
            S_IDLE:  if (start)        state_d = S_ADDR;
            S_ADDR:  if (w_phase_last) state_d = S_AHOLD;
            S_AHOLD: if (w_phase_last) state_d = S_TURN;
            S_TURN:  if (w_phase_last) state_d = S_READ;
            S_READ:  if (w_phase_last) begin
                cap_d   = bus.ad_in;
                state_d = S_RECOV;
            end
            S_RECOV: if (w_phase_last) state_d = S_DONE;
            S_DONE: begin
                state_d = S_IDLE;
                if (w_ok) begin
                    year_bcd_d = cap_q;
                    year_bin_d = w_bin;
                    valid_d    = 1'b1;
                end else begin
                    err_d      = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        phase_d = ((state_d != state_q) || (state_q == S_IDLE)) ? 4'd0 : phase_q + 4'd1;

        // Bus outputs are decoded from the next state so they register in step with it.
        cs_n_d   = 1'b1;
        ad_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = 8'h00;
        busy_d   = (state_d != S_IDLE);
        unique case (state_d)
            S_ADDR:  begin cs_n_d = 1'b0; ad_n_d = 1'b0; ad_oe_d = 1'b1; ad_out_d = ADDR_YEAR; end
            S_AHOLD: begin cs_n_d = 1'b0; ad_oe_d = 1'b1; ad_out_d = ADDR_YEAR; end
            S_TURN:  cs_n_d = 1'b0;
            S_READ:  begin cs_n_d = 1'b0; rd_n_d = 1'b0; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            phase_q    <= 4'd0;
            cap_q      <= 8'h00;
            cs_n_q     <= 1'b1;
            ad_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            ad_oe_q    <= 1'b0;
            ad_out_q   <= 8'h00;
            busy_q     <= 1'b0;
            year_bcd_q <= 8'h00;
            year_bin_q <= 7'd0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cap_q      <= cap_d;
            cs_n_q     <= cs_n_d;
            ad_n_q     <= ad_n_d;
            rd_n_q     <= rd_n_d;
            ad_oe_q    <= ad_oe_d;
            ad_out_q   <= ad_out_d;
            busy_q     <= busy_d;
            year_bcd_q <= year_bcd_d;
            year_bin_q <= year_bin_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign bus.cs_n   = cs_n_q;
    assign bus.ad_n   = ad_n_q;
    assign bus.rd_n   = rd_n_q;
    assign bus.ad_oe  = ad_oe_q;
    assign bus.ad_out = ad_out_q;
    assign busy       = busy_q;
    assign year_bcd   = year_bcd_q;
    assign year_bin   = year_bin_q;
    assign valid      = valid_q;
    assign err        = err_q;
endmodule : lector_ad_year
`default_nettype wire

// File: tb/tb_lector_ad_year.sv
`default_nettype none
// ============================================================================
// Module   : tb_lector_ad_year
// Brief    : Directed-vector bench: one reader at T_PHASE=4, one at T_PHASE=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lector_ad_year;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start4 = 1'b0, start1 = 1'b0;
    logic busy4, busy1, valid4, valid1, err4, err1;
    logic [7:0] bcd4, bcd1;
    logic [6:0] bin4, bin1;
    logic [7:0] data4 = 8'h00, data1 = 8'h00;
    logic [7:0] lat_a4 = 8'h00, lat_a1 = 8'h00;
    int rc4 = 0, rc1 = 0;
    int n_vec = 0, n_fail = 0, viol = 0, both = 0;

    always #5 clk = ~clk;

    lector_ad_year_if if4 ();
    lector_ad_year_if if1 ();

    lector_ad_year #(.ADDR_YEAR(8'h26), .T_PHASE(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .bus(if4.master), .busy(busy4),
        .year_bcd(bcd4), .year_bin(bin4), .valid(valid4), .err(err4));

    lector_ad_year #(.ADDR_YEAR(8'h26), .T_PHASE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .bus(if1.master), .busy(busy1),
        .year_bcd(bcd1), .year_bin(bin1), .valid(valid1), .err(err1));

    // RTC model: latches the address strobe and only has data ready in the last READ cycle.
    always @(posedge clk) begin
        if (!if4.cs_n && !if4.ad_n && if4.ad_oe) lat_a4 <= if4.ad_out;
        if (!if1.cs_n && !if1.ad_n && if1.ad_oe) lat_a1 <= if1.ad_out;
        rc4 <= (!if4.rd_n) ? rc4 + 1 : 0;
        rc1 <= (!if1.rd_n) ? rc1 + 1 : 0;
    end
    assign if4.ad_in = (!if4.cs_n && !if4.rd_n && rc4 >= 3 && lat_a4 == 8'h26) ? data4 : 8'hEE;
    assign if1.ad_in = (!if1.cs_n && !if1.rd_n && lat_a1 == 8'h26) ? data1 : 8'hEE;

    always @(negedge clk) begin
        if ((if4.ad_oe && !if4.rd_n) || (if1.ad_oe && !if1.rd_n)) viol++;
        if ((valid4 && err4) || (valid1 && err1)) both++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_txn(input bit one, input bit rel, input logic [7:0] d,
                           output int lat, output logic v, output logic e,
                           output logic [7:0] bcd, output logic [6:0] bin);
        lat = -1; v = 1'b0; e = 1'b0; bcd = 8'h00; bin = 7'd0;
        if (one) data1 = d; else data4 = d;
        @(negedge clk);
        if (rel) reset = 1'b1;
        if (one) start1 = 1'b1; else start4 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        if (rel) chk("busy_after_release", int'(one ? busy1 : busy4), 1);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (one ? (valid1 | err1) : (valid4 | err4)) begin
                lat = k + 1;
                v   = one ? valid1 : valid4;
                e   = one ? err1 : err4;
                bcd = one ? bcd1 : bcd4;
                bin = one ? bin1 : bin4;
                break;
            end
        end
        if (lat >= 0) begin
            @(posedge clk); #1;
            chk("pulse_width", int'(one ? (valid1 | err1) : (valid4 | err4)), 0);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       ev;
        logic       ee;
        logic [7:0] ebcd;
        logic [6:0] ebin;
    } vec_t;

    vec_t tbl[8];

    initial begin : main
        int lat, p1, p2, np;
        logic v, e, b22, b23;
        logic [7:0] bcd;
        logic [6:0] bin;

        tbl[0] = '{8'h16, 1'b1, 1'b0, 8'h16, 7'd16};
        tbl[1] = '{8'h99, 1'b1, 1'b0, 8'h99, 7'd99};
        tbl[2] = '{8'h00, 1'b1, 1'b0, 8'h00, 7'd0};
        tbl[3] = '{8'h42, 1'b1, 1'b0, 8'h42, 7'd42};
        tbl[4] = '{8'h3A, 1'b0, 1'b1, 8'h42, 7'd42};
        tbl[5] = '{8'h9F, 1'b0, 1'b1, 8'h42, 7'd42};
        tbl[6] = '{8'hA0, 1'b0, 1'b1, 8'h42, 7'd42};
        tbl[7] = '{8'h59, 1'b1, 1'b0, 8'h59, 7'd59};

        #12;
        chk("rst_cs_n", int'(if4.cs_n), 1);
        chk("rst_ad_oe", int'(if4.ad_oe), 0);
        chk("rst_ad_out", int'(if4.ad_out), 0);
        chk("rst_busy", int'(busy4), 0);
        chk("rst_year", int'({bcd4, bin4, valid4, err4}), 0);

        for (int i = 0; i < 8; i++) begin
            run_txn(1'b0, i == 0, tbl[i].data, lat, v, e, bcd, bin);
            chk("latency", lat, 22);
            chk("valid", int'(v), int'(tbl[i].ev));
            chk("err", int'(e), int'(tbl[i].ee));
            chk("year_bcd", int'(bcd), int'(tbl[i].ebcd));
            chk("year_bin", int'(bin), int'(tbl[i].ebin));
        end

        // Reset while in READ
        data4 = 8'h77;
        @(negedge clk); start4 = 1'b1;
        @(posedge clk); #1; start4 = 1'b0;
        repeat (13) @(posedge clk);
        #1 chk("in_read_rd_n", int'(if4.rd_n), 0);
        #1 reset = 1'b0;
        #1;
        chk("abort_cs_n", int'(if4.cs_n), 1);
        chk("abort_ad_oe", int'(if4.ad_oe), 0);
        chk("abort_busy", int'(busy4), 0);
        chk("abort_year", int'({bcd4, bin4}), 0);
        np = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (valid4 | err4) np++;
        end
        chk("abort_no_pulse", np, 0);
        run_txn(1'b0, 1'b1, 8'h21, lat, v, e, bcd, bin);
        chk("post_reset_latency", lat, 22);
        chk("post_reset_valid", int'(v), 1);
        chk("post_reset_bin", int'(bin), 21);

        // start held high for 30 cycles
        data4 = 8'h08;
        p1 = -1; p2 = -1; np = 0; b22 = 1'b1; b23 = 1'b0;
        @(negedge clk); start4 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 43; k++) begin
            @(posedge clk); #1;
            if (k + 1 == 30) start4 = 1'b0;
            if (k + 1 == 22) b22 = busy4;
            if (k + 1 == 23) b23 = busy4;
            if (valid4 | err4) begin
                np++;
                if (p1 < 0) p1 = k + 1; else p2 = k + 1;
            end
        end
        chk("held_first_pulse", p1, 22);
        chk("held_idle_busy", int'(b22), 0);
        chk("held_restart_busy", int'(b23), 1);
        chk("held_second_pulse", p2, 44);
        chk("held_pulse_count", np, 2);
        chk("held_bcd", int'(bcd4), 8'h08);

        // T_PHASE = 1 instance
        run_txn(1'b1, 1'b0, 8'h37, lat, v, e, bcd, bin);
        chk("t1_latency", lat, 7);
        chk("t1_valid", int'(v), 1);
        chk("t1_bin", int'(bin), 37);
        run_txn(1'b1, 1'b0, 8'h5B, lat, v, e, bcd, bin);
        chk("t1_err_latency", lat, 7);
        chk("t1_err", int'(e), 1);
        chk("t1_bcd_kept", int'(bcd), 8'h37);

        chk("oe_during_rd", viol, 0);
        chk("valid_and_err", both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule : tb_lector_ad_year
`default_nettype wire
